// File: rtl/search_path_pipe_pkg.sv
// Shared constants and helpers for the search_path_pipe elastic register pipeline.
package search_path_pipe_pkg;

  localparam int unsigned MinWidth   = 1;
  localparam int unsigned MinDepth   = 1;
  localparam logic        RstDataBit = 1'b0;

  // Enough bits to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/search_path_pipe_if.sv
// Valid/ready bus for search_path_pipe; occupancy present only with SEARCH_PATH_PIPE_OCC_EN.
interface search_path_pipe_if
  import search_path_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_data_n;
`ifdef SEARCH_PATH_PIPE_OCC_EN
  localparam int unsigned OccW = occ_width(DEPTH);
  logic [OccW-1:0]  occupancy;
`endif

  modport master (
    output flush, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_data_n
`ifdef SEARCH_PATH_PIPE_OCC_EN
    , input occupancy
`endif
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_data_n
`ifdef SEARCH_PATH_PIPE_OCC_EN
    , output occupancy
`endif
  );

endinterface

// File: rtl/search_pipe_stage.sv
// One elastic pipeline stage: valid/data register pair with a combinational ready chain.
module search_pipe_stage
  import search_path_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load_data;

  assign o_ready     = ~r_valid | i_ready;
  // Data only moves with a valid word so bubbles never overwrite it.
  assign w_load_data = o_ready & i_valid & ~i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= {WIDTH{RstDataBit}};
    end else if (w_load_data) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/search_path_pipe.sv
// Elastic WIDTH x DEPTH register pipeline fed by in_a & in_b, with true and inverted outputs.
// Optional occupancy counter enabled by defining SEARCH_PATH_PIPE_OCC_EN.
module search_path_pipe
  import search_path_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  search_path_pipe_if.slave   bus
);

  if (WIDTH < MinWidth || DEPTH < MinDepth) begin : g_param_err
    $error("search_path_pipe: WIDTH and DEPTH must be at least 1");
  end

  // Index 0 is the front end; index i+1 is the output of stage i.
  logic [DEPTH:0]            w_valid;
  logic [DEPTH:0][WIDTH-1:0] w_data;
  logic [DEPTH:0]            w_ready;

  assign w_valid[0]     = bus.in_valid;
  assign w_data[0]      = bus.in_a & bus.in_b;
  assign w_ready[DEPTH] = bus.out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    search_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.flush),
      .i_valid (w_valid[i]),
      .i_data  (w_data[i]),
      .i_ready (w_ready[i+1]),
      .o_valid (w_valid[i+1]),
      .o_data  (w_data[i+1]),
      .o_ready (w_ready[i])
    );
  end

  assign bus.in_ready   = w_ready[0] & ~bus.flush;
  assign bus.out_valid  = w_valid[DEPTH] & ~bus.flush;
  assign bus.out_data   = w_data[DEPTH];
  assign bus.out_data_n = ~w_data[DEPTH];

`ifdef SEARCH_PATH_PIPE_OCC_EN
  localparam int unsigned OccW = occ_width(DEPTH);

  logic            w_xfer_in;
  logic            w_xfer_out;
  logic [OccW-1:0] r_occ;

  assign w_xfer_in  = bus.in_valid & bus.in_ready;
  assign w_xfer_out = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (bus.flush) begin
      r_occ <= '0;
    end else if (w_xfer_in && !w_xfer_out) begin
      r_occ <= r_occ + OccW'(1);
    end else if (w_xfer_out && !w_xfer_in) begin
      r_occ <= r_occ - OccW'(1);
    end
  end

  assign bus.occupancy = r_occ;
`endif

endmodule

// File: doc/search_path_pipe.md
# search_path_pipe

Parametrised elastic register pipeline for timing-search regression designs: generalises the fixed two-register, reset-able reg-to-reg chain to WIDTH bits and DEPTH stages with valid/ready flow control. The front end is a combinational bitwise AND of two input buses, so paths run input-to-register, register-to-register and register-to-output. Outputs carry both true and inverted data. The block is intended as a scalable stimulus for path-end and backpressure path analysis.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 2, number of register stages (≥1)
- clk  input  1  rising-edge clock, only clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all stage valids
- in_valid  input  1  upstream word valid
- in_ready  output  1  pipeline can accept this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  last stage holds valid word
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  last-stage data
- out_data_n  output  WIDTH  bitwise inverse of out_data
- occupancy  output  $clog2(DEPTH+1)  valid stage count (only with SEARCH_PATH_PIPE_OCC_EN)

## Operation
- Stage input word = in_a & in_b (bitwise), no register before stage 0.
- Stage i holds v[i], d[i]; r[DEPTH] = out_ready; r[i] = ~v[i] | r[i+1] (combinational ready chain).
- in_ready = r[0] & ~flush; out_valid = v[DEPTH-1] & ~flush; out_data = d[DEPTH-1].
- Stage load when r[i]: v[i] ← v[i-1] (v[-1] = in_valid); d[i] ← d[i-1] only if v[i-1] (data holds on bubble).
- When ~r[i]: stage holds v and d.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- flush: next cycle all v = 0; d untouched; no transfer in or out counted that cycle; flush dominates.
- Full (all v = 1) with out_ready = 0: in_ready = 0, everything holds.
- Full with out_ready = 1: in_ready = 1, simultaneous in/out transfer, occupancy unchanged.
- Bubbles collapse: a stalled tail does not block stages behind an empty stage.

## Timing
- Reset (async assert, sync-deassert by caller): all v = 0, all d = 0 → out_valid 0, out_data 0, out_data_n all ones, occupancy 0, in_ready 1 (when flush 0).
- Latency: word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1 (visible cycle N+DEPTH) with no stall.
- Throughput: one word per cycle sustained with out_ready held 1.
- out_ready → in_ready is a combinational path through all DEPTH stages; intended.
- rst mid-stream: all in-flight words lost immediately, no partial output.

## Configuration
- SEARCH_PATH_PIPE_OCC_EN defined: occupancy port and registered counter present; +1 on transfer in only, −1 on transfer out only, unchanged on both or neither, 0 on flush or rst; never exceeds DEPTH.
- Undefined: no occupancy port, no counter logic; all other behaviour identical.

## Structure
- Package search_path_pipe_pkg: occupancy width function (clog2(DEPTH+1)), reset data constant (all zeros), minimum-parameter constants.
- Sub-module search_pipe_stage: one v/d register pair with load/hold logic and ready output; top instantiates DEPTH copies via generate plus AND front end, output inversion and counter.

## Test plan
- WIDTH=8, DEPTH=3; rst pulse mid-cycle → out_valid 0, out_data 0x00, out_data_n 0xFF, occupancy 0 asynchronously.
- in_a=0xF0, in_b=0x3C, in_valid at cycle 1, out_ready 1 → out_valid and out_data 0x30, out_data_n 0xCF at cycle 4.
- Stream 5 words, out_ready 0 from cycle 2 → in_ready drops after 3 accepted, occupancy 3; release out_ready → words emerge in order, no loss or duplication.
- Full pipe, out_ready 1, in_valid 1 → in_ready 1, one in and one out per cycle, occupancy stays 3.
- Full pipe, assert flush one cycle with in_valid 1 → in_ready 0, out_valid 0 that cycle; next cycle occupancy 0, out_valid 0, flushed input not accepted.
- Alternate in_valid 1/0 with out_ready toggling → bubbles collapse; scoreboard matches in_a&in_b sequence exactly.
